// File: rtl/qerv_pcgen_pkg.sv
// Shared types and helpers for the qerv program-counter generator.
// The optional misaligned-jump trap is enabled by QERV_PCGEN_MISALIGN_EN.
package qerv_pcgen_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_UPDATE = 2'd1,
    ST_FETCH  = 2'd2
  } state_e;

  localparam logic [31:0] PC_INC_FULL = 32'd4;
  localparam logic [31:0] PC_INC_COMP = 32'd2;
  localparam logic [31:0] UIMM_MASK   = 32'hFFFF_F000;
  localparam logic [31:0] CSR_PC_MASK = 32'hFFFF_FFFC;

  // Number of serial beats needed to move a 32-bit word through W lanes.
  function automatic int beats(input int w);
    return 32 / w;
  endfunction

  // Width of the beat index; never narrower than one bit.
  function automatic int beat_w(input int w);
    return ((32 / w) > 1) ? $clog2(32 / w) : 1;
  endfunction

endpackage

// File: rtl/qerv_pcgen_ser_add.sv
// W-bit slice of a bit-serial adder. The carry is held between beats,
// ignored on the first beat and dropped after the last one.
module qerv_pcgen_ser_add #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         i_rst,
  input  logic         i_en,
  input  logic         i_clr,
  input  logic         i_flush,
  input  logic [W-1:0] i_a,
  input  logic [W-1:0] i_b,
  output logic [W-1:0] o_sum
);

  logic         r_carry;
  logic         w_cin;
  logic [W:0]   w_full;

  assign w_cin  = i_clr ? 1'b0 : r_carry;
  assign w_full = {1'b0, i_a} + {1'b0, i_b} + {{W{1'b0}}, w_cin};
  assign o_sum  = w_full[W-1:0];

  always_ff @(posedge clk) begin
    if (i_rst || i_flush) begin
      r_carry <= 1'b0;
    end else if (i_en) begin
      r_carry <= w_full[W];
    end
  end

endmodule

// File: rtl/qerv_pcgen.sv
// Program-counter generator for W-bit-serial qerv cores: serial PC update,
// rd / bad-PC streams and ibus fetch. Optional: QERV_PCGEN_MISALIGN_EN.
module qerv_pcgen
  import qerv_pcgen_pkg::*;
#(
  parameter int          W              = 1,
  parameter logic [31:0] RESET_PC       = 32'd0,
  parameter string       RESET_STRATEGY = "MINI",
  parameter bit          WITH_CSR       = 1'b1,
  parameter bit          BOOT_FETCH     = 1'b1,
  localparam int         CW             = beat_w(W)
) (
  input  logic          clk,
  input  logic          i_rst,
  input  logic          i_pc_start,
  input  logic          i_jump,
  input  logic          i_jal_or_jalr,
  input  logic          i_utype,
  input  logic          i_pc_rel,
  input  logic          i_trap,
  input  logic          i_iscomp,
  input  logic [W-1:0]  i_imm,
  input  logic [W-1:0]  i_buf,
  input  logic [W-1:0]  i_csr_pc,
  output logic          o_beat_en,
  output logic [CW-1:0] o_beat,
  output logic [W-1:0]  o_rd,
  output logic [W-1:0]  o_bad_pc,
  output logic [31:0]   o_ibus_adr,
  output logic          o_ibus_cyc,
  input  logic          i_ibus_ack,
  output logic          o_fetch_done,
`ifdef QERV_PCGEN_MISALIGN_EN
  output logic          o_misalign,
`endif
  output logic [1:0]    o_dbg_state
);

  localparam int            BEATS     = beats(W);
  localparam logic [CW-1:0] LAST_BEAT = CW'(BEATS - 1);
  // Both supported strategies initialise the PC; FSM and carries always reset.
  localparam bit PC_HAS_RESET = (RESET_STRATEGY == "MINI") || (RESET_STRATEGY == "NONE");

  state_e        r_state;
  state_e        w_state_nxt;
  logic [CW-1:0] r_beat;
  logic [31:0]   r_pc;
  logic          r_fetch_done;

  logic          w_update;
  logic          w_first;
  logic          w_last;
  logic          w_trap;
  logic          w_skip_fetch;
  logic [31:0]   w_shift;
  logic [31:0]   w_inc_vec;
  logic [W-1:0]  w_pc_lane;
  logic [W-1:0]  w_inc_lane;
  logic [W-1:0]  w_uimm_mask;
  logic [W-1:0]  w_csr_mask;
  logic [W-1:0]  w_rel_a;
  logic [W-1:0]  w_off_b;
  logic [W-1:0]  w_p4;
  logic [W-1:0]  w_off_raw;
  logic [W-1:0]  w_off;
  logic [W-1:0]  w_new;
  logic [W+31:0] w_pc_cat;

  assign w_update  = (r_state == ST_UPDATE);
  assign w_first   = (r_beat == '0);
  assign w_last    = w_update && (r_beat == LAST_BEAT);
  assign w_trap    = WITH_CSR & i_trap;
  assign w_shift   = 32'(r_beat) * 32'(W);
  assign w_inc_vec = i_iscomp ? PC_INC_COMP : PC_INC_FULL;

  // The PC shifts right each beat, so its low W bits are always the current lane.
  assign w_pc_lane   = r_pc[W-1:0];
  assign w_inc_lane  = W'(w_inc_vec >> w_shift);
  assign w_uimm_mask = W'(UIMM_MASK >> w_shift);
  assign w_csr_mask  = W'(CSR_PC_MASK >> w_shift);
  assign w_rel_a     = i_pc_rel ? w_pc_lane : '0;
  assign w_off_b     = i_utype ? (i_imm & w_uimm_mask) : i_buf;

  qerv_pcgen_ser_add #(.W(W)) u_add_inc (
    .clk     (clk),
    .i_rst   (i_rst),
    .i_en    (w_update),
    .i_clr   (w_first),
    .i_flush (w_last),
    .i_a     (w_pc_lane),
    .i_b     (w_inc_lane),
    .o_sum   (w_p4)
  );

  qerv_pcgen_ser_add #(.W(W)) u_add_off (
    .clk     (clk),
    .i_rst   (i_rst),
    .i_en    (w_update),
    .i_clr   (w_first),
    .i_flush (w_last),
    .i_a     (w_rel_a),
    .i_b     (w_off_b),
    .o_sum   (w_off_raw)
  );

  // Target bit 0 is always cleared; only the sum output is masked, not the carry.
  assign w_off    = w_off_raw & ~W'(w_first);
  assign w_new    = w_trap ? (i_csr_pc & w_csr_mask) : (i_jump ? w_off : w_p4);
  assign w_pc_cat = {w_new, r_pc};

`ifdef QERV_PCGEN_MISALIGN_EN
  localparam logic [CW-1:0] MIS_BEAT = CW'(1 / W);
  localparam int            MIS_BIT  = 1 % W;

  logic r_misalign;
  logic w_mis_now;

  assign w_mis_now    = w_update && (r_beat == MIS_BEAT) && i_jump && w_off[MIS_BIT];
  assign w_skip_fetch = w_mis_now | r_misalign;
  assign o_misalign   = r_misalign;

  always_ff @(posedge clk) begin
    if (i_rst) begin
      r_misalign <= 1'b0;
    end else if ((r_state == ST_IDLE) && i_pc_start) begin
      r_misalign <= 1'b0;
    end else if (w_mis_now) begin
      r_misalign <= 1'b1;
    end
  end
`else
  assign w_skip_fetch = 1'b0;
`endif

  // ibus handshake: o_ibus_cyc is high for the whole FETCH state with o_ibus_adr
  // stable; the request completes on the first cycle i_ibus_ack is seen high in
  // FETCH, and ack in any other state is ignored.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:   if (i_pc_start) w_state_nxt = ST_UPDATE;
      ST_UPDATE: if (w_last)     w_state_nxt = w_skip_fetch ? ST_IDLE : ST_FETCH;
      ST_FETCH:  if (i_ibus_ack) w_state_nxt = ST_IDLE;
      default:                   w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (i_rst) begin
      r_state      <= BOOT_FETCH ? ST_FETCH : ST_IDLE;
      r_beat       <= '0;
      r_fetch_done <= 1'b0;
      if (PC_HAS_RESET) r_pc <= RESET_PC;
    end else begin
      r_state      <= w_state_nxt;
      r_fetch_done <= (r_state == ST_FETCH) && i_ibus_ack;
      if (w_update) begin
        r_pc   <= w_pc_cat[W+31:W];
        r_beat <= w_last ? '0 : r_beat + 1'b1;
      end
    end
  end

  assign o_beat_en    = w_update;
  assign o_beat       = r_beat;
  assign o_rd         = (i_utype ? w_off : '0) | (i_jal_or_jalr ? w_p4 : '0);
  assign o_bad_pc     = w_off;
  assign o_ibus_adr   = r_pc;
  assign o_ibus_cyc   = (r_state == ST_FETCH);
  assign o_fetch_done = r_fetch_done;
  assign o_dbg_state  = r_state;

endmodule

// File: tb/tb_qerv_pcgen.sv
// Bench for qerv_pcgen: one instance per lane width, each driven by a shared
// vector table, random operations checked against a word-level model, and reset cases.
module tb_qerv_pcgen;
  import qerv_pcgen_pkg::*;

  localparam int NCFG  = 6;
  localparam int NVEC  = 12;
  localparam int NRAND = 30;

  typedef struct packed {
    logic        jump;
    logic        jal;
    logic        utype;
    logic        pc_rel;
    logic        trap;
    logic        iscomp;
    logic [31:0] imm;
    logic [31:0] bufv;
    logic [31:0] csr;
  } op_t;

  typedef struct packed {
    op_t         op;
    logic [31:0] e_pc;
    logic [31:0] e_pc_nocsr;
    logic [31:0] e_rd;
    logic [31:0] e_bad;
  } vec_t;

  typedef struct packed {
    logic [31:0] npc;
    logic [31:0] rd;
    logic [31:0] bad;
  } res_t;

  logic clk;
  int   n_vec;
  int   n_err;
  int   n_done;
  vec_t tab [NVEC];

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic int cfg_w(input int g);
    case (g)
      0:       return 1;
      1:       return 2;
      2:       return 4;
      3:       return 8;
      4:       return 16;
      default: return 32;
    endcase
  endfunction

  function automatic bit cfg_boot(input int g);
    return g != 1;
  endfunction

  function automatic bit cfg_csr(input int g);
    return g != 3;
  endfunction

  // Word-level reference: the whole 32-bit result computed in one step.
  function automatic res_t ref_model(input logic [31:0] pc, input op_t op, input bit with_csr);
    res_t        r;
    logic [31:0] p4;
    logic [31:0] off;
    p4  = pc + (op.iscomp ? 32'd2 : 32'd4);
    off = (op.pc_rel ? pc : 32'd0) + (op.utype ? (op.imm & 32'hFFFF_F000) : op.bufv);
    off[0] = 1'b0;
    if (with_csr && op.trap) r.npc = op.csr & 32'hFFFF_FFFC;
    else if (op.jump)        r.npc = off;
    else                     r.npc = p4;
    r.rd  = (op.utype ? off : 32'd0) | (op.jal ? p4 : 32'd0);
    r.bad = off;
    return r;
  endfunction

  function automatic bit exp_fetch(input logic jump, input logic [31:0] target);
`ifdef QERV_PCGEN_MISALIGN_EN
    return !(jump && target[1]);
`else
    return 1'b1;
`endif
  endfunction

  function automatic op_t rand_op();
    op_t op;
    op.jump   = 1'($urandom_range(0, 1));
    op.jal    = 1'($urandom_range(0, 1));
    op.utype  = ($urandom_range(0, 3) == 0);
    op.pc_rel = 1'($urandom_range(0, 1));
    op.trap   = ($urandom_range(0, 7) == 0);
    op.iscomp = 1'($urandom_range(0, 1));
    op.imm    = $urandom;
    op.bufv   = $urandom;
    op.csr    = $urandom;
    return op;
  endfunction

  function automatic vec_t mk(input logic jump, jal, utype, pc_rel, trap, iscomp,
                              input logic [31:0] imm, bufv, csr, e_pc, e_pc_nocsr, e_rd, e_bad);
    vec_t v;
    v.op = '{jump: jump, jal: jal, utype: utype, pc_rel: pc_rel, trap: trap,
             iscomp: iscomp, imm: imm, bufv: bufv, csr: csr};
    v.e_pc = e_pc;
    v.e_pc_nocsr = e_pc_nocsr;
    v.e_rd = e_rd;
    v.e_bad = e_bad;
    return v;
  endfunction

  task automatic chk(input int g, input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL cfg%0d %s: got 0x%08h expected 0x%08h", g, name, act, exp);
    end
  endtask

  // Applied in order from PC=0x100; each row's PC follows from the row before.
  //       jmp jal ut  rel trp cmp imm            buf            csr            pc             pc(no csr)     rd             bad
  initial begin
    n_vec = 0; n_err = 0; n_done = 0;
    tab[0]  = mk(0, 0, 0, 0, 0, 0, 32'h0,          32'h0,          32'h0,          32'h0000_0104, 32'h0000_0104, 32'h0,          32'h0);
    tab[1]  = mk(0, 0, 0, 0, 0, 1, 32'h0,          32'h0,          32'h0,          32'h0000_0106, 32'h0000_0106, 32'h0,          32'h0);
    tab[2]  = mk(1, 0, 0, 0, 0, 0, 32'h0,          32'h0000_1000,  32'h0,          32'h0000_1000, 32'h0000_1000, 32'h0,          32'h0000_1000);
    tab[3]  = mk(1, 1, 0, 1, 0, 0, 32'h0,          32'h0000_0020,  32'h0,          32'h0000_1020, 32'h0000_1020, 32'h0000_1004,  32'h0000_1020);
    tab[4]  = mk(0, 0, 1, 1, 0, 0, 32'h1234_5FFF,  32'h0,          32'h0,          32'h0000_1024, 32'h0000_1024, 32'h1234_6020,  32'h1234_6020);
    tab[5]  = mk(0, 0, 1, 0, 0, 0, 32'hABCD_E123,  32'h0,          32'h0,          32'h0000_1028, 32'h0000_1028, 32'hABCD_E000,  32'hABCD_E000);
    tab[6]  = mk(1, 1, 0, 0, 0, 1, 32'h0,          32'hFFFF_FFFD,  32'h0,          32'hFFFF_FFFC, 32'hFFFF_FFFC, 32'h0000_102A,  32'hFFFF_FFFC);
    tab[7]  = mk(0, 1, 0, 0, 0, 0, 32'h0,          32'h0,          32'h0,          32'h0000_0000, 32'h0000_0000, 32'h0,          32'h0);
    tab[8]  = mk(1, 0, 0, 1, 0, 0, 32'h0,          32'hFFFF_FFF0,  32'h0,          32'hFFFF_FFF0, 32'hFFFF_FFF0, 32'h0,          32'hFFFF_FFF0);
    tab[9]  = mk(1, 0, 0, 0, 0, 0, 32'h0,          32'h0000_1002,  32'h0,          32'h0000_1002, 32'h0000_1002, 32'h0,          32'h0000_1002);
    tab[10] = mk(0, 0, 0, 0, 0, 0, 32'h0,          32'h0,          32'h0,          32'h0000_1006, 32'h0000_1006, 32'h0,          32'h0);
    tab[11] = mk(0, 0, 0, 0, 1, 0, 32'h0,          32'h0,          32'h8000_0003,  32'h8000_0000, 32'h0000_100A, 32'h0,          32'h0);
  end

  for (genvar g = 0; g < NCFG; g++) begin : g_cfg
    localparam int GW    = cfg_w(g);
    localparam int GB    = 32 / GW;
    localparam int GCW   = (GB > 1) ? $clog2(GB) : 1;
    localparam bit GBOOT = cfg_boot(g);
    localparam bit GCSR  = cfg_csr(g);

    logic           rst, start, jump, jal, utype, pc_rel, trap, iscomp, ack;
    logic [GW-1:0]  imm, bufv, csr;
    logic           beat_en, cyc, fdone;
    logic [GCW-1:0] beat;
    logic [GW-1:0]  rd, bad;
    logic [31:0]    adr;
    logic [1:0]     dbg;
`ifdef QERV_PCGEN_MISALIGN_EN
    logic           mis;
`endif

    qerv_pcgen #(
      .W(GW), .RESET_PC(32'h100), .RESET_STRATEGY("MINI"),
      .WITH_CSR(GCSR), .BOOT_FETCH(GBOOT)
    ) u_dut (
      .clk           (clk),
      .i_rst         (rst),
      .i_pc_start    (start),
      .i_jump        (jump),
      .i_jal_or_jalr (jal),
      .i_utype       (utype),
      .i_pc_rel      (pc_rel),
      .i_trap        (trap),
      .i_iscomp      (iscomp),
      .i_imm         (imm),
      .i_buf         (bufv),
      .i_csr_pc      (csr),
      .o_beat_en     (beat_en),
      .o_beat        (beat),
      .o_rd          (rd),
      .o_bad_pc      (bad),
      .o_ibus_adr    (adr),
      .o_ibus_cyc    (cyc),
      .i_ibus_ack    (ack),
      .o_fetch_done  (fdone),
`ifdef QERV_PCGEN_MISALIGN_EN
      .o_misalign    (mis),
`endif
      .o_dbg_state   (dbg)
    );

    // Holds ack off for dly cycles, then pulses it once; a fetch completes only if one was pending.
    task automatic fetch_ack(input bit e_fetch, input logic [31:0] e_adr, input int dly);
      repeat (dly) @(posedge clk);
      @(negedge clk);
      chk(g, "cyc_hold", cyc, e_fetch);
      chk(g, "adr_hold", adr, e_adr);
      @(posedge clk); #1;
      ack = 1'b1;
      @(posedge clk); #1;
      ack = 1'b0;
      @(negedge clk);
      chk(g, "fetch_done", fdone, e_fetch);
      chk(g, "cyc_after_ack", cyc, 0);
      chk(g, "state_idle", dbg, ST_IDLE);
      @(negedge clk);
      chk(g, "fetch_done_pulse", fdone, 0);
    endtask

    task automatic do_reset(input int edges);
      rst = 1'b1; start = 1'b0; ack = 1'b0;
      repeat (edges) @(posedge clk);
      #1;
      rst = 1'b0;
      @(negedge clk);
      chk(g, "rst_adr", adr, 32'h100);
      chk(g, "rst_cyc", cyc, GBOOT);
      chk(g, "rst_beat_en", beat_en, 0);
      chk(g, "rst_fetch_done", fdone, 0);
      chk(g, "rst_state", dbg, GBOOT ? ST_FETCH : ST_IDLE);
`ifdef QERV_PCGEN_MISALIGN_EN
      chk(g, "rst_misalign", mis, 0);
`endif
      fetch_ack(GBOOT, 32'h100, 0);
    endtask

    task automatic drive_ctrl(input op_t op);
      jump = op.jump; jal = op.jal; utype = op.utype;
      pc_rel = op.pc_rel; trap = op.trap; iscomp = op.iscomp;
    endtask

    task automatic drive_lane(input op_t op, input int b);
      imm  = op.imm[b*GW +: GW];
      bufv = op.bufv[b*GW +: GW];
      csr  = op.csr[b*GW +: GW];
    endtask

    // One full instruction: start pulse, GB beats, then the fetch (or its absence).
    task automatic run_op(input op_t op, input logic [31:0] e_pc, e_rd, e_bad, input bit rnd);
      logic [31:0] got_rd, got_bad;
      int          n_ok;
      bit          e_fetch;
      e_fetch = exp_fetch(op.jump, e_bad);
      got_rd = '0; got_bad = '0; n_ok = 0;
      @(posedge clk); #1;
      drive_ctrl(op);
      start = 1'b1;
      @(posedge clk); #1;
      for (int b = 0; b < GB; b++) begin
        start = rnd ? 1'($urandom_range(0, 1)) : 1'b0;
        ack   = rnd ? 1'($urandom_range(0, 1)) : 1'b0;
        drive_lane(op, b);
        @(negedge clk);
        if (beat_en && (32'(beat) == b)) n_ok++;
        got_rd[b*GW +: GW]  = rd;
        got_bad[b*GW +: GW] = bad;
`ifdef QERV_PCGEN_MISALIGN_EN
        if (b == 0) chk(g, "misalign_cleared", mis, 0);
`endif
        @(posedge clk); #1;
      end
      start = 1'b0; ack = 1'b0;
      @(negedge clk);
      chk(g, "beat_seq", n_ok, GB);
      chk(g, "beat_en_off", beat_en, 0);
      chk(g, "rd", got_rd, e_rd);
      chk(g, "bad_pc", got_bad, e_bad);
      chk(g, "new_pc", adr, e_pc);
      chk(g, "cyc", cyc, e_fetch);
      chk(g, "no_early_done", fdone, 0);
`ifdef QERV_PCGEN_MISALIGN_EN
      chk(g, "misalign", mis, !e_fetch);
`endif
      fetch_ack(e_fetch, e_pc, rnd ? $urandom_range(0, 3) : 0);
    endtask

    initial begin
      op_t         op;
      res_t        r;
      logic [31:0] m_pc;
      logic [31:0] e_pc;
      {jump, jal, utype, pc_rel, trap, iscomp} = '0;
      imm = '0; bufv = '0; csr = '0;
      do_reset(2);
      m_pc = 32'h100;
      for (int i = 0; i < NVEC; i++) begin
        e_pc = (tab[i].op.trap && !GCSR) ? tab[i].e_pc_nocsr : tab[i].e_pc;
        run_op(tab[i].op, e_pc, tab[i].e_rd, tab[i].e_bad, 1'b0);
        m_pc = e_pc;
      end
      for (int i = 0; i < NRAND; i++) begin
        op = rand_op();
        r  = ref_model(m_pc, op, GCSR);
        run_op(op, r.npc, r.rd, r.bad, 1'b1);
        m_pc = r.npc;
      end
      // Reset in the middle of an update must discard the partial PC.
      op = rand_op();
      @(posedge clk); #1;
      drive_ctrl(op);
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      for (int b = 0; b < ((GB > 5) ? 5 : GB - 1); b++) begin
        drive_lane(op, b);
        @(posedge clk); #1;
      end
      do_reset(1);
      m_pc = 32'h100;
      for (int i = 0; i < 5; i++) begin
        op = rand_op();
        r  = ref_model(m_pc, op, GCSR);
        run_op(op, r.npc, r.rd, r.bad, 1'b1);
        m_pc = r.npc;
      end
      n_done++;
    end
  end

  initial begin
    for (int c = 0; (c < 60000) && (n_done < NCFG); c++) @(posedge clk);
    if (n_done < NCFG) begin
      n_vec++;
      n_err++;
      $display("FAIL timeout: %0d of %0d configs finished", n_done, NCFG);
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
